// File: rtl/bram_stream_pkg.sv
// Shared types and sizing helpers for the BRAM stream reader.
// Pure declarations: no logic, no latency, no flow control of its own.
package bram_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Room for every read that can be in the memory pipeline plus two beats of slack.
   function automatic int fifo_depth(input int read_latency);
      return read_latency + 2;
   endfunction

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// Synchronous FIFO carrying {last, data}; head word is visible combinationally, 1-cycle write-to-read.
// Backpressure: push is dropped when full, pop ignored when empty; flush empties it in one cycle.
module stream_fifo #(
   parameter  int WIDTH = 9,
   parameter  int DEPTH = 4,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign pop_dat = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Storage is cleared too so the stream outputs read zero while in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: rtl/bram_stream_reader.sv
// Sweeps a wrapping BRAM address range and streams the words out; first beat 4 cycles after start.
// Reads are issued only while pipeline+FIFO occupancy has room, so m_ready backpressure never loses data.
module bram_stream_reader
   import bram_stream_pkg::*;
#(
   parameter  int RAM_WIDTH    = 8,
   parameter  int RAM_DEPTH    = 1024,
   parameter  int READ_LATENCY = 2,
   localparam int AW           = addr_width(RAM_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [AW-1:0]        base_addr,
   input  logic [AW:0]          length,
   input  logic                 abort,
   output logic [AW-1:0]        bram_addr,
   input  logic [RAM_WIDTH-1:0] bram_dout,
   output logic [RAM_WIDTH-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last,
   output logic                 busy,
   output logic                 done
);

   localparam int FD = fifo_depth(READ_LATENCY);
   localparam int CW = $clog2(FD + 1);

   state_e                  state_q, state_d;
   logic [AW-1:0]           addr_q, addr_d;
   logic [AW:0]             remain_q, remain_d;
   logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
   logic [READ_LATENCY-1:0] last_pipe_q, last_pipe_d;
   logic                    done_q, done_d;

   logic [CW-1:0]           fifo_count;
   logic [CW-1:0]           inflight;
   logic [CW:0]             occupancy;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    issue;
   logic                    issue_last;
   logic [AW-1:0]           addr_next;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         inflight = inflight + CW'(vld_pipe_q[i]);
      end
   end

   assign occupancy  = {1'b0, inflight} + {1'b0, fifo_count};
   assign issue      = (state_q == RUN) && !abort && (remain_q != '0) &&
                       (occupancy < (CW+1)'(FD));
   assign issue_last = issue && (remain_q == (AW+1)'(1));
   assign addr_next  = (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;

   // The delayed valid bit lines up with bram_dout exactly READ_LATENCY cycles after issue.
   assign fifo_push  = vld_pipe_q[READ_LATENCY-1];
   assign fifo_pop   = m_valid && m_ready;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      done_d   = 1'b0;
      vld_pipe_d[0]  = issue;
      last_pipe_d[0] = issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
         vld_pipe_d[i]  = vld_pipe_q[i-1];
         last_pipe_d[i] = last_pipe_q[i-1];
      end

      if (abort) begin
         state_d     = IDLE;
         vld_pipe_d  = '0;
         last_pipe_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (length == '0) begin
                     done_d = 1'b1;
                  end else begin
                     state_d  = RUN;
                     addr_d   = base_addr;
                     remain_d = length;
                  end
               end
            end
            RUN: begin
               if (issue) begin
                  addr_d   = addr_next;
                  remain_d = remain_q - 1'b1;
                  if (issue_last) begin
                     state_d = DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (fifo_pop && m_last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remain_q    <= '0;
         vld_pipe_q  <= '0;
         last_pipe_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remain_q    <= remain_d;
         vld_pipe_q  <= vld_pipe_d;
         last_pipe_q <= last_pipe_d;
         done_q      <= done_d;
      end
   end

   stream_fifo #(
      .WIDTH (RAM_WIDTH + 1),
      .DEPTH (FD)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (abort),
      .push     (fifo_push),
      .push_dat ({last_pipe_q[READ_LATENCY-1], bram_dout}),
      .pop      (fifo_pop),
      .pop_dat  ({m_last, m_data}),
      .count    (fifo_count),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   // The issue rule reserves a slot for every read in flight, so a push can never meet a full FIFO.
   assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full && !abort));

   assign bram_addr = addr_q;
   assign m_valid   = !fifo_empty;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

   localparam int W  = 8;
   localparam int D  = 1024;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic          m_ready;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic [AW-1:0] bram_addr;
   logic [AW-1:0] addr_r;
   logic [W-1:0]  bram_dout;
   logic [W-1:0]  m_data;
   logic          m_valid;
   logic          m_last;
   logic          busy;
   logic          done;
   logic [W-1:0]  mem [D];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // Two-register memory model: address flop then output flop.
   always @(posedge clk) begin
      addr_r    <= bram_addr;
      bram_dout <= mem[addr_r];
   end

   bram_stream_reader #(
      .RAM_WIDTH    (W),
      .RAM_DEPTH    (D),
      .READ_LATENCY (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .abort     (abort),
      .bram_addr (bram_addr),
      .bram_dout (bram_dout),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last),
      .busy      (busy),
      .done      (done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem(input bit random_fill);
      for (int i = 0; i < D; i++) begin
         mem[i] = random_fill ? W'($urandom_range(0, 255)) : W'(i & 8'hFF);
      end
   endtask

   // Runs one sweep; mode 0 ready high, 1 alternating, 2 low for 20 cycles, 3 random.
   task automatic sweep(input int base, input int len, input int mode, input int abort_after,
                        output int first_vld, output int last_cyc, output int done_cyc,
                        output int got);
      logic [W-1:0] exp_q[$];
      int     cyc, acc, changes, last_addr, budget;
      logic   pv, pl;
      logic [W-1:0] pd;
      bit     fin, do_abort;
      for (int k = 0; k < len; k++) exp_q.push_back(mem[(base + k) % D]);
      first_vld = -1; last_cyc = -1; done_cyc = -1;
      acc = 0; changes = 0; pv = 1'b0; pl = 1'b0; pd = '0; fin = 1'b0;
      budget = len * 4 + 80;
      start = 1'b1; base_addr = AW'(base); length = (AW+1)'(len); m_ready = 1'b0;
      step();
      start = 1'b0;
      cyc = 1;
      last_addr = base;
      vectors++;
      if (bram_addr !== AW'(base)) begin
         miscompares++;
         $display("FAIL first_addr: got %0d want %0d", bram_addr, base);
      end
      while (!fin && cyc < budget) begin
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'(cyc % 2);
            2:       m_ready = (cyc >= 21);
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         do_abort = (abort_after > 0) && (acc == abort_after);
         if (do_abort) begin
            abort = 1'b1;
            m_ready = 1'b0;
         end
         if (int'(bram_addr) != last_addr) begin
            changes++;
            vectors++;
            if (int'(bram_addr) != (last_addr + 1) % D) begin
               miscompares++;
               $display("FAIL addr_step: got %0d want %0d", bram_addr, (last_addr + 1) % D);
            end
            last_addr = int'(bram_addr);
         end
         vectors++;
         if (changes - acc > 4) begin
            miscompares++;
            $display("FAIL occupancy: got %0d outstanding want <= 4", changes - acc);
         end
         if (pv) begin
            vectors++;
            if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
               miscompares++;
               $display("FAIL stall_stable: got v%0b d%0h l%0b want v1 d%0h l%0b",
                        m_valid, m_data, m_last, pd, pl);
            end
         end
         if (first_vld < 0 && m_valid === 1'b1) first_vld = cyc;
         if (done === 1'b1) begin
            done_cyc = cyc;
            fin = 1'b1;
            vectors++;
            if (acc != len || busy !== 1'b0 || m_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL done_state: got beats %0d busy %0b valid %0b want beats %0d busy 0 valid 0",
                        acc, busy, m_valid, len);
            end
         end else begin
            vectors++;
            if (busy !== 1'b1) begin
               miscompares++;
               $display("FAIL busy_run: got %0b want 1 at cycle %0d", busy, cyc);
            end
         end
         if (!fin && m_valid === 1'b1 && m_ready === 1'b1) begin
            vectors++;
            if (acc >= len) begin
               miscompares++;
               $display("FAIL extra_beat: got beat %0d want at most %0d", acc + 1, len);
            end else if (m_data !== exp_q[acc] || m_last !== (acc == len - 1)) begin
               miscompares++;
               $display("FAIL beat: got d%0h l%0b want d%0h l%0b (beat %0d)",
                        m_data, m_last, exp_q[acc], (acc == len - 1), acc);
            end
            if (acc == len - 1) last_cyc = cyc;
            acc++;
         end
         pv = m_valid && !m_ready;
         pd = m_data;
         pl = m_last;
         step();
         cyc++;
         if (do_abort) begin
            abort = 1'b0;
            vectors++;
            if (m_valid !== 1'b0 || busy !== 1'b0) begin
               miscompares++;
               $display("FAIL abort_next: got valid %0b busy %0b want 0 0", m_valid, busy);
            end
            for (int k = 0; k < 10; k++) begin
               vectors++;
               if (done !== 1'b0 || m_valid !== 1'b0) begin
                  miscompares++;
                  $display("FAIL abort_quiet: got done %0b valid %0b want 0 0", done, m_valid);
               end
               step();
            end
            fin = 1'b1;
         end
      end
      if (!fin) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout: got no done after %0d cycles want done", budget);
      end else if (done_cyc > 0) begin
         vectors++;
         if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: got %0b want 0 one cycle after done", done);
         end
      end
      got = acc;
      m_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({bram_addr, m_data, m_valid, m_last, busy, done} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got addr %0h data %0h v%0b l%0b b%0b d%0b want all 0",
                  bram_addr, m_data, m_valid, m_last, busy, done);
      end
      #3 rst_n = 1'b1;
      step();
   endtask

   task automatic test_plain();
      int fv, lc, dc, got;
      fill_mem(1'b0);
      sweep(32'h010, 4, 0, 0, fv, lc, dc, got);
      vectors++;
      if (fv != 4 || lc != 7 || dc != 8) begin
         miscompares++;
         $display("FAIL plain_timing: got first %0d last %0d done %0d want 4 7 8", fv, lc, dc);
      end
   endtask

   task automatic test_backpressure();
      int fv, lc, dc, got;
      fill_mem(1'b1);
      sweep($urandom_range(0, D - 1), 8, 1, 0, fv, lc, dc, got);
      sweep($urandom_range(0, D - 1), 8, 2, 0, fv, lc, dc, got);
      vectors++;
      if (got != 8) begin
         miscompares++;
         $display("FAIL hold_loss: got %0d beats want 8", got);
      end
   endtask

   task automatic test_wrap();
      int fv, lc, dc, got;
      fill_mem(1'b1);
      sweep(1022, 4, 0, 0, fv, lc, dc, got);
      vectors++;
      if (got != 4 || dc != 8) begin
         miscompares++;
         $display("FAIL wrap: got beats %0d done %0d want 4 8", got, dc);
      end
   endtask

   task automatic test_zero_length();
      start = 1'b1; base_addr = AW'($urandom_range(0, D - 1)); length = '0;
      step();
      start = 1'b0;
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_len: got done %0b busy %0b valid %0b want 1 0 0", done, busy, m_valid);
      end
      for (int k = 0; k < 6; k++) begin
         step();
         vectors++;
         if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_quiet: got done %0b busy %0b valid %0b want 0 0 0", done, busy, m_valid);
         end
      end
   endtask

   task automatic test_abort();
      int fv, lc, dc, got;
      fill_mem(1'b1);
      sweep($urandom_range(0, D - 1), 16, 0, 3, fv, lc, dc, got);
      vectors++;
      if (got != 3 || dc != -1) begin
         miscompares++;
         $display("FAIL abort_count: got beats %0d done %0d want 3 -1", got, dc);
      end
      sweep(0, 2, 0, 0, fv, lc, dc, got);
      vectors++;
      if (got != 2) begin
         miscompares++;
         $display("FAIL after_abort: got %0d beats want 2", got);
      end
   endtask

   task automatic test_abort_with_start();
      start = 1'b1; abort = 1'b1; base_addr = '0; length = (AW+1)'(5);
      step();
      start = 1'b0; abort = 1'b0;
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_start: got busy %0b done %0b valid %0b want 0 0 0", busy, done, m_valid);
         end
         step();
      end
   endtask

   task automatic test_full_depth();
      int fv, lc, dc, got;
      fill_mem(1'b1);
      sweep($urandom_range(0, D - 1), D, 0, 0, fv, lc, dc, got);
      vectors++;
      if (got != D || dc != D + 4) begin
         miscompares++;
         $display("FAIL full_depth: got beats %0d done %0d want %0d %0d", got, dc, D, D + 4);
      end
   endtask

   task automatic test_random();
      int fv, lc, dc, got;
      fill_mem(1'b1);
      for (int n = 0; n < 8; n++) begin
         sweep($urandom_range(0, D - 1), $urandom_range(1, 40), 3, 0, fv, lc, dc, got);
      end
   endtask

   task automatic test_async_reset();
      int fv, lc, dc, got;
      start = 1'b1; base_addr = AW'($urandom_range(0, D - 1)); length = (AW+1)'(4);
      m_ready = 1'b0;
      step();
      start = 1'b0;
      repeat (5) step();
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({bram_addr, m_data, m_valid, m_last, busy, done} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: got addr %0h data %0h v%0b l%0b b%0b d%0b want all 0",
                  bram_addr, m_data, m_valid, m_last, busy, done);
      end
      #2 rst_n = 1'b1;
      step();
      vectors++;
      if (busy !== 1'b0 || m_valid !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset: got busy %0b valid %0b done %0b want 0 0 0", busy, m_valid, done);
      end
      sweep($urandom_range(0, D - 1), 5, 3, 0, fv, lc, dc, got);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
      base_addr = '0; length = '0;
      fill_mem(1'b0);
      test_reset();
      test_plain();
      test_backpressure();
      test_wrap();
      test_zero_length();
      test_abort();
      test_abort_with_start();
      test_full_depth();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side consumer for port A of the team's dual-port BRAM, which has 2-cycle read latency.
- On a start command it sweeps a contiguous (wrapping) address range and issues one read address per cycle.
- It re-times the latency-delayed read data into a valid/ready output stream.
- A credit-limited output FIFO absorbs backpressure without losing in-flight reads.
- It sits between the BRAM and any downstream stream sink (e.g. a bus bridge or UART packer).

Parameters:
- RAM_WIDTH, 8, data word width; must match the memory.
- RAM_DEPTH, 1024, number of memory words.
- READ_LATENCY, 2, cycles from the address being presented to valid read data.

Ports:
- clk  in  1  single clock, shared with the memory's port A.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- base_addr  in  AW  first address of the sweep. AW = $clog2(RAM_DEPTH), equal to the memory address port width.
- length  in  AW+1  number of words to read, 0..RAM_DEPTH.
- abort  in  1  cancels the sweep; highest priority after reset.
- bram_addr  out  AW  drives the memory's addra.
- bram_dout  in  RAM_WIDTH  the memory's douta.
- m_data  out  RAM_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final beat of the sweep.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, rst_n low):
  - All outputs go to 0 immediately, with no clock edge needed.
  - The FSM, counters, in-flight pipeline and FIFO are all cleared.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start with length > 0.
  - IDLE -> IDLE with a done pulse in the next cycle on start with length == 0; no beats are produced.
  - RUN -> DRAIN once `length` reads have been issued.
  - DRAIN -> IDLE when the beat carrying m_last is accepted (m_valid & m_ready). done is asserted in the following cycle.
  - start is ignored in RUN and DRAIN.
- Address generation:
  - The address register is loaded with base_addr on an accepted start.
  - It increments after each issued read and wraps from RAM_DEPTH-1 to 0. Wrap is explicit, so non-power-of-two depths are supported.
  - bram_addr holds its value when no read is issued.
- Read-issue rule:
  - A read is issued in a RUN cycle only when inflight + fifo_count < FIFO_DEPTH, where FIFO_DEPTH = READ_LATENCY+2.
  - inflight is tracked by a READ_LATENCY-deep valid/last shift register.
  - The outputs of issued reads are captured into the FIFO exactly READ_LATENCY cycles after issue.
- Latency and throughput:
  - Start in cycle 0 gives bram_addr = base in cycle 1 and bram_dout valid in cycle 3.
  - The first m_valid appears in cycle 4.
  - Sustained rate is 1 beat/cycle while m_ready is held high.
- Stream rules:
  - m_data, m_last and m_valid are stable while m_valid & !m_ready.
  - Beats leave in address order, with no drops or duplicates.
  - m_last is asserted only on beat `length`.
- Abort, in any state:
  - Next state is IDLE.
  - The FIFO and in-flight pipeline are flushed.
  - m_valid is 0 in the next cycle.
  - No done pulse is generated.
  - busy deasserts in the next cycle.
- Simultaneous events:
  - abort together with start in IDLE: abort wins and the start is dropped.
  - FIFO push and pop in the same cycle: the count is unchanged.
- Boundary case: length = RAM_DEPTH reads every word exactly once, starting from base.

Decomposition:
- Package bram_stream_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - the FIFO_DEPTH derivation (READ_LATENCY+2);
  - the AW derivation helper.
- One sub-module, stream_fifo:
  - synchronous FIFO, parameterised by width and depth, with async active-low reset;
  - exposes push, pop, count, empty, full;
  - carries {last, data}.

Test Plan:
- Plain sweep: mem[i]=i&0xFF, base=0x010, length=4, m_ready=1.
  - bram_addr steps 0x010..0x013 in cycles 1-4.
  - Beats 0x10, 0x11, 0x12, 0x13 arrive in cycles 4-7, with m_last on 0x13.
  - done is asserted in cycle 8; busy is high in cycles 1-7.
- Backpressure: length=8, m_ready alternating 1,0.
  - All 8 beats arrive in order, and data is stable while stalled.
  - inflight+fifo_count never exceeds 4.
  - Holding m_ready=0 for 20 cycles produces no loss.
- Wrap: base=1022, length=4, RAM_DEPTH=1024.
  - Addresses issued are 1022, 1023, 0, 1.
  - Data matches those words, with m_last on the word from address 1.
- Zero length: start with length=0.
  - done is asserted in cycle 1.
  - m_valid and busy are never asserted.
- Abort: length=16, abort asserted after the 3rd beat is accepted.
  - m_valid is 0 in the next cycle; no done pulse occurs.
  - A subsequent start with base=0, length=2 delivers exactly mem[0] and mem[1].
- Async reset: rst_n pulsed low mid-DRAIN, between clock edges.
  - All outputs read 0 before the next edge.
  - After release, the block is idle and accepts a new start.
